// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback-stage controller
//
// Contents:
//   wb_sel_e   : writeback mux source codes (ALU, load data, PC+4)
//   wb_state_e : controller FSM states
//   RF_ADDR_W  : register-file address width
//   map_sel    : folds the reserved source code 2'b11 onto the ALU source
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC4 = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_RSP = 2'b01,
        ERROR    = 2'b10
    } wb_state_e;

    localparam int RF_ADDR_W = 5;

    function automatic logic [1:0] map_sel(input logic [1:0] sel);
        return (sel == 2'b11) ? WB_ALU : sel;
    endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// rtl/wb_ctrl_if.sv - handshake bundle between the MEM/WB pipeline register, data memory and wb_ctrl
//
// Signals:
//   wb_valid_i, wb_sel_i, reg_wr_i, rd_i : writeback instruction fields from MEM/WB
//   dmem_rsp_valid_i                     : load data valid on the memory output
//   sel_dm_o, rf_we_o, rf_waddr_o        : writeback mux select and register-file write port
//   stall_o, load_pending_o, timeout_o   : pipeline freeze and status
// Modports:
//   master : pipeline/memory side (drives instruction fields and response valid)
//   slave  : wb_ctrl side
interface wb_ctrl_if;
    import wb_pkg::*;

    logic                 wb_valid_i;
    logic [1:0]           wb_sel_i;
    logic                 reg_wr_i;
    logic [RF_ADDR_W-1:0] rd_i;
    logic                 dmem_rsp_valid_i;
    logic [1:0]           sel_dm_o;
    logic                 rf_we_o;
    logic [RF_ADDR_W-1:0] rf_waddr_o;
    logic                 stall_o;
    logic                 load_pending_o;
    logic                 timeout_o;

    modport master (
        output wb_valid_i, wb_sel_i, reg_wr_i, rd_i, dmem_rsp_valid_i,
        input  sel_dm_o, rf_we_o, rf_waddr_o, stall_o, load_pending_o, timeout_o
    );

    modport slave (
        input  wb_valid_i, wb_sel_i, reg_wr_i, rd_i, dmem_rsp_valid_i,
        output sel_dm_o, rf_we_o, rf_waddr_o, stall_o, load_pending_o, timeout_o
    );

endinterface

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - load-wait watchdog counter with clear, enable and terminal count
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count up by one
//   tc         : count equals TIMEOUT_CYCLES-1
module wb_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_ctrl.sv
// rtl/wb_ctrl.sv - writeback-stage controller: mux select, register-file write, load stall, watchdog
//
// Ports:
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : wb_ctrl_if.slave (instruction fields, memory response, writeback controls, status)
// Parameters:
//   TIMEOUT_CYCLES : maximum WAIT_RSP cycles before ERROR (2..255)
//   CNT_W          : watchdog counter width
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_ctrl_if.slave  bus
);

    wb_state_e            state, state_nxt;
    logic [RF_ADDR_W-1:0] rd_q;
    logic                 reg_wr_q;
    logic                 tmr_clr, tmr_en, tmr_tc;
    logic                 is_load;

    assign is_load = bus.wb_valid_i && (bus.wb_sel_i == WB_MEM);

    wb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    // Outputs are combinational so a response completes its write in the
    // same cycle it arrives; no output register sits between FSM and mux.
    always_comb begin
        state_nxt      = state;
        bus.sel_dm_o   = WB_ALU;
        bus.rf_we_o    = 1'b0;
        bus.rf_waddr_o = bus.rd_i;
        bus.stall_o    = 1'b0;
        tmr_clr        = 1'b0;
        tmr_en         = 1'b0;
        case (state)
            IDLE: begin
                if (is_load) begin
                    bus.sel_dm_o = WB_MEM;
                    if (bus.dmem_rsp_valid_i) begin
                        bus.rf_we_o = bus.reg_wr_i && (bus.rd_i != '0);
                    end else begin
                        bus.stall_o = 1'b1;
                        tmr_clr     = 1'b1;
                        state_nxt   = WAIT_RSP;
                    end
                end else if (bus.wb_valid_i) begin
                    bus.sel_dm_o = map_sel(bus.wb_sel_i);
                    bus.rf_we_o  = bus.reg_wr_i && (bus.rd_i != '0);
                end
            end
            WAIT_RSP: begin
                // Upstream is frozen: only the response input is live here.
                bus.sel_dm_o   = WB_MEM;
                bus.rf_waddr_o = rd_q;
                if (bus.dmem_rsp_valid_i) begin
                    // A response on the threshold cycle still wins.
                    bus.rf_we_o = reg_wr_q && (rd_q != '0);
                    state_nxt   = IDLE;
                end else begin
                    bus.stall_o = 1'b1;
                    tmr_en      = 1'b1;
                    if (tmr_tc) begin
                        state_nxt = ERROR;
                    end
                end
            end
            ERROR: begin
                bus.rf_waddr_o = rd_q;
                bus.stall_o    = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.load_pending_o = (state == WAIT_RSP);
    assign bus.timeout_o      = (state == ERROR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_q     <= '0;
            reg_wr_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (tmr_clr) begin
                rd_q     <= bus.rd_i;
                reg_wr_q <= bus.reg_wr_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb/tb_wb_ctrl.sv - self-checking bench for wb_ctrl with a behavioural load-tracking model
module tb_wb_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   run = 1'b0;
    int   checks = 0;
    int   failures = 0;

    wb_ctrl_if bus();

    wb_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding load is a record (rd, reg_wr) plus the number of
    // wait cycles already spent; once that number reaches TMO the memory is hung.
    bit       m_pend, m_hung, m_wr;
    int       m_waited;
    int       m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend   <= 1'b0;
            m_hung   <= 1'b0;
            m_waited <= 0;
            m_rd     <= 0;
            m_wr     <= 1'b0;
        end else if (m_hung) begin
            m_hung <= 1'b1;
        end else if (m_pend) begin
            if (bus.dmem_rsp_valid_i) begin
                m_pend <= 1'b0;
            end else if (m_waited + 1 == TMO) begin
                m_pend <= 1'b0;
                m_hung <= 1'b1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (bus.wb_valid_i && bus.wb_sel_i == 2'd1 && !bus.dmem_rsp_valid_i) begin
            m_pend   <= 1'b1;
            m_waited <= 0;
            m_rd     <= int'(bus.rd_i);
            m_wr     <= bus.reg_wr_i;
        end
    end

    // Compare every cycle, mid-low phase, away from the rising edge.
    always @(negedge clk) begin
        int e_sel, e_we, e_wa, e_stall, e_pend, e_to;
        if (run) begin
            e_sel = 0; e_we = 0; e_wa = -1; e_stall = 0; e_pend = 0; e_to = 0;
            if (m_hung) begin
                e_stall = 1;
                e_to    = 1;
            end else if (m_pend) begin
                e_sel  = 1;
                e_pend = 1;
                if (bus.dmem_rsp_valid_i) begin
                    e_we = (m_wr && m_rd != 0) ? 1 : 0;
                    e_wa = m_rd;
                end else begin
                    e_stall = 1;
                end
            end else if (bus.wb_valid_i) begin
                if (bus.wb_sel_i == 2'd1) begin
                    e_sel = 1;
                    if (bus.dmem_rsp_valid_i) begin
                        e_we = (bus.reg_wr_i && bus.rd_i != 0) ? 1 : 0;
                        e_wa = int'(bus.rd_i);
                    end else begin
                        e_stall = 1;
                    end
                end else begin
                    e_sel = (bus.wb_sel_i == 2'd3) ? 0 : int'(bus.wb_sel_i);
                    e_we  = (bus.reg_wr_i && bus.rd_i != 0) ? 1 : 0;
                    e_wa  = int'(bus.rd_i);
                end
            end
            chk("cyc_sel", 32'(bus.sel_dm_o), e_sel);
            chk("cyc_we", 32'(bus.rf_we_o), e_we);
            if (e_we == 1) chk("cyc_waddr", 32'(bus.rf_waddr_o), e_wa);
            chk("cyc_stall", 32'(bus.stall_o), e_stall);
            chk("cyc_pending", 32'(bus.load_pending_o), e_pend);
            chk("cyc_timeout", 32'(bus.timeout_o), e_to);
        end
    end

    task automatic step(input logic v, input logic [1:0] s, input logic w,
                        input logic [4:0] rd, input logic rsp);
        @(posedge clk);
        #1;
        bus.wb_valid_i       = v;
        bus.wb_sel_i         = s;
        bus.reg_wr_i         = w;
        bus.rd_i             = rd;
        bus.dmem_rsp_valid_i = rsp;
        #1;
    endtask

    initial begin
        bus.wb_valid_i = 1'b0; bus.wb_sel_i = 2'd0; bus.reg_wr_i = 1'b0;
        bus.rd_i = 5'd0; bus.dmem_rsp_valid_i = 1'b0;
        #2;
        run = 1'b1;
        repeat (2) @(posedge clk);
        chk("reset_stall", 32'(bus.stall_o), 0);
        chk("reset_pending", 32'(bus.load_pending_o), 0);
        chk("reset_timeout", 32'(bus.timeout_o), 0);
        chk("reset_we", 32'(bus.rf_we_o), 0);
        #1 rst_n = 1'b1;

        // Non-load writes
        step(1, 2'd0, 1, 5'd5, 0);
        chk("alu_sel", 32'(bus.sel_dm_o), 0);
        chk("alu_we", 32'(bus.rf_we_o), 1);
        chk("alu_waddr", 32'(bus.rf_waddr_o), 5);
        chk("alu_stall", 32'(bus.stall_o), 0);
        step(1, 2'd2, 1, 5'd1, 0);
        chk("jal_sel", 32'(bus.sel_dm_o), 2);
        chk("jal_we", 32'(bus.rf_we_o), 1);
        step(1, 2'd0, 1, 5'd0, 0);
        chk("x0_we", 32'(bus.rf_we_o), 0);
        step(1, 2'd3, 1, 5'd4, 0);
        chk("rsvd_sel", 32'(bus.sel_dm_o), 0);

        // Zero-wait load
        step(1, 2'd1, 1, 5'd7, 1);
        chk("zw_we", 32'(bus.rf_we_o), 1);
        chk("zw_waddr", 32'(bus.rf_waddr_o), 7);
        chk("zw_stall", 32'(bus.stall_o), 0);
        step(0, 2'd0, 0, 5'd0, 0);
        chk("zw_pending", 32'(bus.load_pending_o), 0);

        // 3-cycle load, rd_i wiggles during the stall
        step(1, 2'd1, 1, 5'd9, 0);
        chk("l3_c0_stall", 32'(bus.stall_o), 1);
        step(1, 2'd2, 1, 5'd12, 0);
        chk("l3_c1_stall", 32'(bus.stall_o), 1);
        step(0, 2'd0, 0, 5'd3, 0);
        chk("l3_c2_stall", 32'(bus.stall_o), 1);
        step(1, 2'd0, 1, 5'd20, 1);
        chk("l3_c3_we", 32'(bus.rf_we_o), 1);
        chk("l3_c3_waddr", 32'(bus.rf_waddr_o), 9);
        chk("l3_c3_stall", 32'(bus.stall_o), 0);

        // Spurious response in IDLE
        step(0, 2'd0, 1, 5'd6, 1);
        chk("spur_we", 32'(bus.rf_we_o), 0);

        // Timeout: entry + TMO wait cycles stalled, then ERROR
        step(1, 2'd1, 1, 5'd11, 0);
        for (int i = 0; i < TMO; i++) begin
            step(0, 2'd0, 0, 5'd0, 0);
            chk("tmo_wait_stall", 32'(bus.stall_o), 1);
            chk("tmo_wait_to", 32'(bus.timeout_o), 0);
        end
        step(0, 2'd0, 0, 5'd0, 0);
        chk("tmo_to", 32'(bus.timeout_o), 1);
        chk("tmo_stall", 32'(bus.stall_o), 1);
        step(1, 2'd0, 1, 5'd8, 1);
        chk("tmo_late_we", 32'(bus.rf_we_o), 0);
        chk("tmo_sticky", 32'(bus.timeout_o), 1);
        bus.wb_valid_i = 1'b0; bus.dmem_rsp_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("tmo_rst_to", 32'(bus.timeout_o), 0);
        chk("tmo_rst_stall", 32'(bus.stall_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Response on the threshold cycle wins
        step(1, 2'd1, 1, 5'd13, 0);
        for (int i = 0; i < TMO - 1; i++) step(0, 2'd0, 0, 5'd0, 0);
        step(0, 2'd0, 0, 5'd0, 1);
        chk("thr_we", 32'(bus.rf_we_o), 1);
        chk("thr_waddr", 32'(bus.rf_waddr_o), 13);
        step(0, 2'd0, 0, 5'd0, 0);
        chk("thr_pending", 32'(bus.load_pending_o), 0);
        chk("thr_to", 32'(bus.timeout_o), 0);

        // Reset two cycles into WAIT_RSP
        step(1, 2'd1, 1, 5'd14, 0);
        step(0, 2'd0, 0, 5'd0, 0);
        step(0, 2'd0, 0, 5'd0, 0);
        bus.wb_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus.stall_o), 0);
        chk("mid_rst_pending", 32'(bus.load_pending_o), 0);
        chk("mid_rst_we", 32'(bus.rf_we_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, 2'd0, 0, 5'd0, 1);
        chk("post_rst_we", 32'(bus.rf_we_o), 0);
        chk("post_rst_pending", 32'(bus.load_pending_o), 0);

        repeat (3) step(0, 2'd0, 0, 5'd0, 0);
        @(posedge clk);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback-stage controller for the simple pipeline. It decides each cycle which source the writeback data mux selects: ALU result, data-memory load data, or PC+4. It also generates the register-file write strobe and address, and stalls the upstream pipeline while a load waits on a variable-latency data-memory response. A watchdog on outstanding loads flags a hung memory.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles a load may wait in WAIT_RSP before ERROR; legal range 2..255.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): width of the wait counter.

Ports:
- clk  in  1  pipeline clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- wb_valid_i  in  1  MEM/WB register holds a valid instruction.
- wb_sel_i  in  2  source code: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- reg_wr_i  in  1  instruction writes rd.
- rd_i  in  5  destination register.
- dmem_rsp_valid_i  in  1  load data is valid on the memory output this cycle.
- sel_dm_o  out  2  writeback mux select.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  5  register-file write address.
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM/WB registers.
- load_pending_o  out  1  state is WAIT_RSP.
- timeout_o  out  1  sticky; state is ERROR.

## Operation
- The FSM has three states: IDLE, WAIT_RSP and ERROR. The reset state is IDLE, with the counter cleared and the latched rd and reg_wr cleared.
- IDLE, wb_valid_i=0: sel_dm_o=00, rf_we_o=0, stall_o=0.
- IDLE, valid non-load (sel 00/10/11): the block writes back in the same cycle.
  - sel_dm_o = wb_sel_i, with 11 mapped to 00.
  - rf_we_o = reg_wr_i && rd_i!=0.
  - rf_waddr_o = rd_i.
  - stall_o=0.
- IDLE, valid load, dmem_rsp_valid_i=1 (zero-wait memory): sel_dm_o=01, the write happens this cycle, stall_o=0, and the FSM stays in IDLE.
- IDLE, valid load, dmem_rsp_valid_i=0:
  - sel_dm_o=01, rf_we_o=0, stall_o=1.
  - Latch rd_i and reg_wr_i, clear the counter, go to WAIT_RSP.
- WAIT_RSP: sel_dm_o=01, rf_waddr_o = latched rd, and all live inputs except dmem_rsp_valid_i are ignored (upstream is frozen).
  - On dmem_rsp_valid_i=1: rf_we_o = latched reg_wr && latched rd!=0, stall_o=0, and the next state is IDLE.
  - Otherwise: stall_o=1 and the counter increments.
  - When the counter equals TIMEOUT_CYCLES-1 with no response, the next state is ERROR.
- ERROR: sel_dm_o=00, rf_we_o=0, stall_o=1, timeout_o=1. Only rst_n exits this state.
- dmem_rsp_valid_i in IDLE without a valid load is ignored, with no write.
- rd=0 never produces rf_we_o=1.

## Timing
- All outputs are combinational from the state register, the latched fields and the current inputs. There are no output registers, so the writeback completes in the same cycle as the response.
- Non-load latency is 0 cycles.
- Load latency is the memory latency N. stall_o is high for exactly N cycles, and the write occurs in the cycle the response arrives.
- Timeout: with no response, stall_o is high for TIMEOUT_CYCLES cycles in WAIT_RSP plus the entry cycle. timeout_o rises in the cycle after the final WAIT_RSP cycle.
- A response and the timeout threshold in the same cycle: the response wins, the write happens, and the next state is IDLE.
- Asserting rst_n=0 mid-WAIT_RSP or in ERROR takes effect immediately and asynchronously:
  - state=IDLE, and the counter and latches are cleared.
  - rf_we_o=0, stall_o=0, load_pending_o=0, timeout_o=0.
  - A dropped load is not replayed.
- Deassertion is assumed to be synchronized upstream, so release is synchronous to clk.

## Structure
- The shared package wb_pkg holds:
  - wb_sel_e (WB_ALU=2'b00, WB_MEM=2'b01, WB_PC4=2'b10).
  - wb_state_e (IDLE, WAIT_RSP, ERROR).
  - RF_ADDR_W=5.
- wb_ctrl drives the existing writeback data mux through sel_dm_o and contains no data path.
- One sub-module, wb_timer: a CNT_W counter with clear, enable and a terminal-count output, which implements the watchdog.

## Test plan
- Non-load writes:
  - ALU op: valid, sel 00, reg_wr=1, rd=5 -> same cycle sel_dm_o=00, rf_we_o=1, rf_waddr_o=5, stall_o=0.
  - JAL: sel 10, rd=1 -> sel_dm_o=10, rf_we_o=1.
  - Write to x0: rd=0 -> rf_we_o=0.
- Zero-wait load: sel 01, rd=7, dmem_rsp_valid_i=1 -> rf_we_o=1, rf_waddr_o=7, stall_o=0, no state change.
- 3-cycle load: sel 01, rd=9, response on cycle 3 -> stall_o=1 for cycles 0-2, rf_we_o=1 with rf_waddr_o=9 on cycle 3, and rd_i changes during the stall are ignored.
- Timeout: TIMEOUT_CYCLES=4 with no response -> ERROR and timeout_o=1, stall_o stays 1, and a later response causes no write.
  - Same setup with the response on the threshold cycle -> the write occurs and the FSM returns to IDLE.
- Reset mid-wait: drop rst_n two cycles into WAIT_RSP -> outputs reset immediately, with no write after release.
- Spurious response in IDLE with no load -> rf_we_o=0.
